// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the combinational program ROM and assembles
// one- and two-word instructions into a registered valid/ready output slot.
module instr_fetch #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [9:0]  IMM_SRC_MASK = 10'h3ff,
    parameter logic [9:0]  IMM_SRC_CODE = 10'h3a0,
    parameter logic [4:0]  BR_OPC       = 5'b11100,
    parameter logic [4:0]  FETCH_OPC    = 5'b11010
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] ins,
    output logic [15:0] ins_imm,
    output logic        ins_two,
    output logic [15:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr
);

    localparam logic [1:0] S_FETCH1 = 2'd0;
    localparam logic [1:0] S_FETCH2 = 2'd1;
    localparam logic [1:0] S_STALL  = 2'd2;

    logic [15:0] pc_q, pc_d;
    logic [1:0]  state_q, state_d;
    logic        resume2_q, resume2_d;
    logic [15:0] ins_q, ins_d;
    logic [15:0] ins_imm_q, ins_imm_d;
    logic        ins_two_q, ins_two_d;
    logic [15:0] ins_pc_q, ins_pc_d;
    logic        ins_valid_q, ins_valid_d;
    logic [15:0] w0_q, w0_d;
    logic [15:0] w0_pc_q, w0_pc_d;

    logic        out_free;
    logic        act_fetch2;
    logic [15:0] pc_inc;

    function automatic logic is_two_word(input logic [15:0] w);
        return ((w[9:0] & IMM_SRC_MASK) == IMM_SRC_CODE) ||
               (w[15:11] == BR_OPC) || (w[15:11] == FETCH_OPC);
    endfunction

    assign rom_addr  = pc_q;
    assign ins       = ins_q;
    assign ins_imm   = ins_imm_q;
    assign ins_two   = ins_two_q;
    assign ins_pc    = ins_pc_q;
    assign ins_valid = ins_valid_q;

    assign out_free   = !ins_valid_q || ins_ready;
    // A stalled fetch resumes as whichever half it was working on.
    assign act_fetch2 = (state_q == S_FETCH2) || ((state_q == S_STALL) && resume2_q);
    assign pc_inc     = pc_q + 16'd1;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
        pc_d        = pc_q;
        state_d     = state_q;
        resume2_d   = resume2_q;
        ins_d       = ins_q;
        ins_imm_d   = ins_imm_q;
        ins_two_d   = ins_two_q;
        ins_pc_d    = ins_pc_q;
        ins_valid_d = ins_valid_q;
        w0_d        = w0_q;
        w0_pc_d     = w0_pc_q;

        if (redirect) begin
            pc_d        = redirect_addr;
            state_d     = S_FETCH1;
            resume2_d   = 1'b0;
            ins_valid_d = 1'b0;
        end else if (!out_free) begin
            state_d   = S_STALL;
            resume2_d = act_fetch2;
        end else if (act_fetch2) begin
            ins_d       = w0_q;
            ins_imm_d   = rom_data;
            ins_two_d   = 1'b1;
            ins_pc_d    = w0_pc_q;
            ins_valid_d = 1'b1;
            pc_d        = pc_inc;
            state_d     = S_FETCH1;
            resume2_d   = 1'b0;
        end else if (is_two_word(rom_data)) begin
            w0_d        = rom_data;
            w0_pc_d     = pc_q;
            ins_valid_d = 1'b0;
            pc_d        = pc_inc;
            state_d     = S_FETCH2;
            resume2_d   = 1'b0;
        end else begin
            ins_d       = rom_data;
            ins_imm_d   = 16'h0000;
            ins_two_d   = 1'b0;
            ins_pc_d    = pc_q;
            ins_valid_d = 1'b1;
            pc_d        = pc_inc;
            state_d     = S_FETCH1;
            resume2_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            state_q     <= S_FETCH1;
            resume2_q   <= 1'b0;
            ins_q       <= 16'h0000;
            ins_imm_q   <= 16'h0000;
            ins_two_q   <= 1'b0;
            ins_pc_q    <= 16'h0000;
            ins_valid_q <= 1'b0;
            w0_q        <= 16'h0000;
            w0_pc_q     <= 16'h0000;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            resume2_q   <= resume2_d;
            ins_q       <= ins_d;
            ins_imm_q   <= ins_imm_d;
            ins_two_q   <= ins_two_d;
            ins_pc_q    <= ins_pc_d;
            ins_valid_q <= ins_valid_d;
            w0_q        <= w0_d;
            w0_pc_q     <= w0_pc_d;
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage between the program ROM and the CPU decode stage.
- Owns the program counter and drives the ROM address; the ROM is combinational, so data returns in the same cycle.
- Assembles one-word and two-word instructions (opcode plus a 16-bit immediate/target word) and presents them to decode with a valid/ready handshake.
- Accepts redirects (jump, branch taken, call, return) from the execute side.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- IMM_SRC_MASK, 10'h3ff, mask applied to instr[9:0] for the long-immediate source test.
- IMM_SRC_CODE, 10'h3a0, instr[9:0] value that marks a long-immediate source.
- BR_OPC, 5'b11100, instr[15:11] value for branch/jump opcodes; these always carry a target word.
- FETCH_OPC, 5'b11010, instr[15:11] value for the fetch-from-memory opcode; it always carries a second word.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rom_addr  out  16  program ROM address; equals pc_q.
- rom_data  in  16  program ROM word for rom_addr, valid in the same cycle.
- ins  out  16  first word of the presented instruction.
- ins_imm  out  16  second word; 16'h0000 for one-word instructions.
- ins_two  out  1  presented instruction is two words.
- ins_pc  out  16  address of the first word of the presented instruction.
- ins_valid  out  1  ins, ins_imm, ins_two and ins_pc are valid.
- ins_ready  in  1  decode accepts the instruction this cycle.
- redirect  in  1  discard in-flight work and continue fetching at redirect_addr.
- redirect_addr  in  16  new PC.

Behaviour:
- Two-word test on a word w: (w[9:0] & IMM_SRC_MASK) == IMM_SRC_CODE, or w[15:11] == BR_OPC, or w[15:11] == FETCH_OPC.
- Registers: pc_q, state, output register set (ins, ins_imm, ins_two, ins_pc, ins_valid), and first-word holding registers (w0_q, w0_pc_q).
- rom_addr = pc_q, combinationally.
- States:
  - FETCH1: sampling a first word.
  - FETCH2: sampling the immediate word.
  - STALL: output register full, decode not ready.
- Output register is "free" when ins_valid=0 or ins_ready=1.
- FETCH1, output free:
  - One-word: load outputs with ins=rom_data, ins_imm=0, ins_two=0, ins_pc=pc_q, valid=1; pc_q+1; stay in FETCH1.
  - Two-word: w0_q=rom_data, w0_pc_q=pc_q; pc_q+1; go to FETCH2. ins_valid falls to 0 if the old output was accepted.
- FETCH2, output free: load outputs with ins=w0_q, ins_imm=rom_data, ins_two=1, ins_pc=w0_pc_q, valid=1; pc_q+1; go to FETCH1.
- Output not free (ins_valid=1, ins_ready=0): hold outputs, pc_q and the holding registers; state becomes STALL and remembers whether to resume in FETCH1 or FETCH2. Leave STALL on the first cycle with ins_ready=1, acting that cycle as the remembered state.
- Latency:
  - One-word instruction: visible the cycle after its address is driven.
  - Two-word instruction: visible 2 cycles after its first address is driven.
  - Sustained throughput: 1 word per cycle.
- Redirect has the highest priority:
  - pc_q=redirect_addr; state=FETCH1; ins_valid=0 next cycle; any half-assembled two-word instruction is dropped.
  - An instruction presented with ins_ready=1 in the same cycle counts as consumed.
  - The first instruction at the target is valid 1 cycle later (one-word) or 2 cycles later (two-word).
- PC arithmetic is 16-bit modulo; 16'hffff increments to 16'h0000 with no flag.
- A two-word instruction whose first word is at 16'hffff takes its immediate from 16'h0000.
- Reset (reset_n=0 at a clock edge), including mid-instruction or mid-stall:
  - pc_q=RESET_PC, state=FETCH1, ins_valid=0, ins=0, ins_imm=0, ins_two=0, ins_pc=0, w0_q=0, w0_pc_q=0.
  - Reset overrides redirect.
- rom_data is never sampled in STALL; the ROM address is held stable while stalled.

Test Plan:
- Reset then release, ins_ready=1, ROM[0]=16'h2201, ROM[1]=16'h0a00 -> ins_valid=0 during reset; cycle 1 after release: ins=2201, ins_pc=0, ins_two=0; next cycle: ins=0a00, ins_pc=1.
- Two-word word pair ROM[7]=16'hfba0, ROM[8]=16'h002b -> ins=fba0, ins_imm=002b, ins_two=1, ins_pc=7 presented once; ins_valid=0 for one cycle between; rom_addr reaches 9.
- ins_ready held low for 3 cycles while ins=16'h0601 is valid -> outputs and rom_addr frozen; on ready, the next word follows with no loss or duplication.
- redirect=1, redirect_addr=16'h002b during FETCH2 of a two-word instruction -> partial instruction dropped; ins_valid=0 next cycle; rom_addr=002b; ROM[2b]=13a0/30d4 presents ins_pc=2b, ins_imm=30d4.
- redirect_addr=16'hffff with ROM[ffff]=16'he005, ROM[0]=16'h0006 -> ins_pc=ffff, ins_imm=0006; pc wraps to 16'h0001.
- reset_n low for one cycle while stalled with a valid output -> ins_valid=0 and pc=RESET_PC next cycle; fetch restarts at 0.
